vlg_design_cnt: RTL and testbench

- Free-running system counter with a clock prescaler.
- A divide-by-DIV prescaler generates a one-cycle tick.
- A CNT_W-bit counter, syscnt, advances by one on each tick and wraps modulo 2^CNT_W.
- Used as a slow system time-base / heartbeat for downstream logic; it has no inputs other than clock and reset.

---
 rtl/vlg_design_cnt_pkg.sv | 17 +
 rtl/vlg_design_cnt_if.sv | 9 +
 rtl/vlg_tick_gen.sv | 41 ++++
 rtl/vlg_design_cnt.sv | 37 +++
 tb/tb_vlg_design_cnt.sv | 117 +++++++++++
 5 files changed

// File: rtl/vlg_design_cnt_pkg.sv
// Shared constants and helpers for the free-running system counter.
// Provides default sizing and the prescaler width calculation.
package vlg_design_cnt_pkg;

    localparam int DIV_DEFAULT   = 20;
    localparam int CNT_W_DEFAULT = 4;

    // A one-bit prescaler is still needed when DIV is 1 so the register stays legal.
    function automatic int presc_width(input int div);
        if (div <= 1) begin
            return 1;
        end else begin
            return $clog2(div);
        end
    endfunction

endpackage

// File: rtl/vlg_design_cnt_if.sv
// Time-base output bundle: the counter drives syscnt, consumers observe it.
interface vlg_design_cnt_if #(
    parameter int CNT_W = 4
);
    logic [CNT_W-1:0] syscnt;

    modport master (output syscnt);
    modport slave  (input  syscnt);
endinterface

// File: rtl/vlg_tick_gen.sv
// Divide-by-DIV prescaler producing a one-cycle tick every DIV clocks.
module vlg_tick_gen
    import vlg_design_cnt_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int             PW   = presc_width(DIV);
    localparam logic [PW-1:0]  LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_r;
    logic          tick_s;

    // Terminal-count decode; with DIV of 1 the prescaler sits at 0 and this is always high.
    always_comb begin
        tick_s = 1'b0;
        if (presc_r == LAST) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Prescaler register; reset is active-high despite the rst_n name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            presc_r <= {PW{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/vlg_design_cnt.sv
// Free-running system time-base: prescaled tick advances a wrapping CNT_W-bit counter.
module vlg_design_cnt
    import vlg_design_cnt_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vlg_design_cnt_if.master     cnt_if
);

    logic             tick_s;
    logic [CNT_W-1:0] syscnt_r;

    vlg_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_s)
    );

    // System count register; wraps naturally modulo 2^CNT_W with no overflow flag.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            syscnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            syscnt_r <= syscnt_r + CNT_W'(1);
        end else begin
            syscnt_r <= syscnt_r;
        end
    end

    assign cnt_if.syscnt = syscnt_r;

endmodule

// File: tb/tb_vlg_design_cnt.sv
// Directed bench for vlg_design_cnt: reset hold, timing table, wrap, async reset, parameter sweep.
module tb_vlg_design_cnt;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_cnt;

    always #5 clk = ~clk;

    vlg_design_cnt_if #(.CNT_W(4)) if_a ();
    vlg_design_cnt_if #(.CNT_W(4)) if_b ();
    vlg_design_cnt_if #(.CNT_W(2)) if_c ();

    vlg_design_cnt #(.DIV(20), .CNT_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .cnt_if(if_a.master));
    vlg_design_cnt #(.DIV(1),  .CNT_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .cnt_if(if_b.master));
    vlg_design_cnt #(.DIV(3),  .CNT_W(2)) dut_c (.clk(clk), .rst_n(rst_n), .cnt_if(if_c.master));

    typedef struct {
        int edge_n;
        int exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    initial begin
        int vi;
        int last_chg;
        int prev;

        // Edge number after release -> expected syscnt of the DIV=20 instance
        vecs[0] = '{19, 0};   vecs[1] = '{20, 1};   vecs[2] = '{39, 1};
        vecs[3] = '{40, 2};   vecs[4] = '{300, 15}; vecs[5] = '{319, 15};
        vecs[6] = '{320, 0};  vecs[7] = '{340, 1};  vecs[8] = '{620, 15};
        vecs[9] = '{640, 0};

        // Reset hold for 1000 ns with the clock running
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("reset_hold_a", {28'd0, if_a.syscnt}, 32'd0);
            check("reset_hold_b", {28'd0, if_b.syscnt}, 32'd0);
            check("reset_hold_c", {30'd0, if_c.syscnt}, 32'd0);
        end

        // Release between edges and run two full wraps of the DIV=20 counter
        @(negedge clk);
        rst_n    = 1'b0;
        edge_cnt = 0;
        vi       = 0;
        last_chg = 0;
        prev     = 0;
        for (int e = 1; e <= 640; e++) begin
            step();
            check("model_div20", {28'd0, if_a.syscnt}, 32'((e / 20) % 16));
            check("model_div1",  {28'd0, if_b.syscnt}, 32'(e % 16));
            check("model_div3",  {30'd0, if_c.syscnt}, 32'((e / 3) % 4));
            if (vi < 10 && vecs[vi].edge_n == edge_cnt) begin
                check("vec_div20", {28'd0, if_a.syscnt}, 32'(vecs[vi].exp));
                vi++;
            end
            if (int'(if_a.syscnt) != prev) begin
                check("mono_inc", {28'd0, if_a.syscnt}, 32'((prev + 1) % 16));
                check("mono_gap", 32'(e - last_chg), 32'd20);
                last_chg = e;
                prev     = int'(if_a.syscnt);
            end
        end
        check("vec_table_done", 32'(vi), 32'd10);
        check("mono_last_change", 32'(last_chg), 32'd640);

        // Mid-count asynchronous reset at edge 130
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n    = 1'b0;
        edge_cnt = 0;
        repeat (130) step();
        check("midcnt_before", {28'd0, if_a.syscnt}, 32'd6);
        #3;
        rst_n = 1'b1;
        #1;
        check("async_clear_a", {28'd0, if_a.syscnt}, 32'd0);
        check("async_clear_b", {28'd0, if_b.syscnt}, 32'd0);
        check("async_clear_c", {30'd0, if_c.syscnt}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b0;
        edge_cnt = 0;
        repeat (19) step();
        check("post_rst_edge19", {28'd0, if_a.syscnt}, 32'd0);
        step();
        check("post_rst_edge20", {28'd0, if_a.syscnt}, 32'd1);
        check("post_rst_div1",   {28'd0, if_b.syscnt}, 32'd4);
        check("post_rst_div3",   {30'd0, if_c.syscnt}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
